// File: rtl/sp_fs_pipe.sv
// sp_fs_pipe: four-lane single-precision floating subtract, rt = ra - rb.
// The operands are registered on entry. Six pipeline stages follow.
// The result is produced six edges after capture. Lanes are independent.
// Results are truncated toward zero. They saturate to +/-Smax on overflow
// and flush to +0 when the magnitude falls below Smin.
module sp_fs_pipe (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [0:127] ra,
    input  logic [0:127] rb,
    input  logic [0:6]   rt_addr,
    input  logic         flush,
    output logic         out_valid,
    output logic [0:127] result,
    output logic [0:6]   rt_wr_addr,
    output logic [0:3]   ovf,
    output logic [0:3]   unf
);

    // Leading-zero count of a 28-bit sum; 28 when the sum is zero.
    function automatic logic [4:0] lzc28(input logic [27:0] v);
        logic [4:0] n;
        n = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (v[i]) n = 5'(27 - i);
        end
        return n;
    endfunction

    // Index 0 is the entry capture; indices 1..6 are stages S1..S6.
    logic [0:6]   vld_reg;
    logic [0:6]   addr_reg [0:5];
    logic [0:127] ra_reg;
    logic [0:127] rb_reg;
    logic [31:0]  pack_word [0:3];
    logic         pack_ovf  [0:3];
    logic         pack_unf  [0:3];

    assign out_valid = vld_reg[6];

    // Valid chain: flush and reset kill every in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg <= '0;
        end else if (flush) begin
            vld_reg <= '0;
        end else begin
            vld_reg <= {in_valid, vld_reg[0:5]};
        end
    end

    // Operand and address capture. The address then travels alongside the data.
    always_ff @(posedge clk) begin
        ra_reg      <= ra;
        rb_reg      <= rb;
        addr_reg[0] <= rt_addr;
        for (int i = 1; i < 6; i++) begin
            addr_reg[i] <= addr_reg[i-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : lane_g
            logic [31:0] a_w, b_w;
            logic [30:0] a_mag, b_mag, big_mag, small_mag;
            logic        swap;
            logic [4:0]  sh;
            logic [53:0] wide;
            logic [26:0] aligned;

            logic        s1_sign_reg, s1_sub_reg;
            logic [7:0]  s1_exp_reg, s1_diff_reg;
            logic [23:0] s1_big_reg, s1_small_reg;
            logic        s2_sign_reg, s2_sub_reg;
            logic [7:0]  s2_exp_reg;
            logic [26:0] s2_big_reg, s2_small_reg;
            logic        s3_sign_reg;
            logic [7:0]  s3_exp_reg;
            logic [27:0] s3_sum_reg;
            logic        s4_sign_reg;
            logic [7:0]  s4_exp_reg;
            logic [27:0] s4_sum_reg;
            logic [4:0]  s4_lzc_reg;
            logic        s5_sign_reg, s5_zero_reg;
            logic signed [9:0] s5_exp_reg;
            logic [27:0] s5_norm_reg;

            assign a_w = ra_reg[32*gi +: 32];
            assign b_w = rb_reg[32*gi +: 32];

            // A zero exponent means zero, so its fraction bits are discarded.
            assign a_mag     = (a_w[30:23] == 8'd0) ? 31'd0 : a_w[30:0];
            assign b_mag     = (b_w[30:23] == 8'd0) ? 31'd0 : b_w[30:0];
            assign swap      = (b_mag > a_mag);
            assign big_mag   = swap ? b_mag : a_mag;
            assign small_mag = swap ? a_mag : b_mag;

            // Alignment frame: 24-bit significand, two guard bits, one sticky bit.
            assign sh      = (s1_diff_reg >= 8'd27) ? 5'd27 : s1_diff_reg[4:0];
            assign wide    = {s1_small_reg, 30'd0} >> sh;
            assign aligned = {wide[53:28], wide[27] | (|wide[26:0])};

            // S1 unpack/swap, S2 align, S3 add/sub, S4 lzc, S5 normalize.
            always_ff @(posedge clk) begin
                s1_sign_reg  <= swap ? ~b_w[31] : a_w[31];
                s1_sub_reg   <= (a_w[31] == b_w[31]);
                s1_exp_reg   <= big_mag[30:23];
                s1_diff_reg  <= big_mag[30:23] - small_mag[30:23];
                s1_big_reg   <= {|big_mag[30:23], big_mag[22:0]};
                s1_small_reg <= {|small_mag[30:23], small_mag[22:0]};

                s2_sign_reg  <= s1_sign_reg;
                s2_sub_reg   <= s1_sub_reg;
                s2_exp_reg   <= s1_exp_reg;
                s2_big_reg   <= {s1_big_reg, 3'd0};
                s2_small_reg <= aligned;

                s3_sign_reg  <= s2_sign_reg;
                s3_exp_reg   <= s2_exp_reg;
                s3_sum_reg   <= s2_sub_reg ? ({1'b0, s2_big_reg} - {1'b0, s2_small_reg})
                                           : ({1'b0, s2_big_reg} + {1'b0, s2_small_reg});

                s4_sign_reg  <= s3_sign_reg;
                s4_exp_reg   <= s3_exp_reg;
                s4_sum_reg   <= s3_sum_reg;
                s4_lzc_reg   <= lzc28(s3_sum_reg);

                s5_sign_reg  <= s4_sign_reg;
                s5_zero_reg  <= (s4_sum_reg == 28'd0);
                s5_norm_reg  <= s4_sum_reg << s4_lzc_reg;
                s5_exp_reg   <= $signed({2'b00, s4_exp_reg}) + 10'sd1
                                - $signed({5'd0, s4_lzc_reg});
            end

            // S6 clamp and pack. An exact zero is always +0 with no flags.
            always_comb begin
                pack_word[gi] = 32'd0;
                pack_ovf[gi]  = 1'b0;
                pack_unf[gi]  = 1'b0;
                if (s5_zero_reg) begin
                    pack_word[gi] = 32'd0;
                end else if (s5_exp_reg >= 10'sd255) begin
                    pack_word[gi] = {s5_sign_reg, 31'h7F7FFFFF};
                    pack_ovf[gi]  = 1'b1;
                end else if (s5_exp_reg <= 10'sd0) begin
                    pack_unf[gi]  = 1'b1;
                end else begin
                    pack_word[gi] = {s5_sign_reg, s5_exp_reg[7:0], s5_norm_reg[26:4]};
                end
            end
        end
    endgenerate

    // Output registers load only for a surviving operation, otherwise they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= '0;
            rt_wr_addr <= '0;
            ovf        <= '0;
            unf        <= '0;
        end else if (vld_reg[5] && !flush) begin
            for (int i = 0; i < 4; i++) begin
                result[32*i +: 32] <= pack_word[i];
                ovf[i]             <= pack_ovf[i];
                unf[i]             <= pack_unf[i];
            end
            rt_wr_addr <= addr_reg[5];
        end
    end

endmodule

// File: tb/tb_sp_fs_pipe.sv
// Testbench for sp_fs_pipe. Stimulus pushes expectations into a scoreboard.
// A negedge monitor pops an expectation for every out_valid. Random traffic
// is checked against an exact wide-integer model of ra - rb.
module tb_sp_fs_pipe;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic [0:127] ra, rb;
    logic [0:6]   rt_addr = '0;
    logic         out_valid;
    logic [0:127] result;
    logic [0:6]   rt_wr_addr;
    logic [0:3]   ovf, unf;

    always #5 clk = ~clk;

    sp_fs_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ra(ra), .rb(rb),
        .rt_addr(rt_addr), .flush(flush), .out_valid(out_valid), .result(result),
        .rt_wr_addr(rt_wr_addr), .ovf(ovf), .unf(unf)
    );

    typedef struct {
        logic [0:127] res;
        logic [0:6]   addr;
        logic [0:3]   ovf;
        logic [0:3]   unf;
        int unsigned  edge_out;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Exact model: each operand becomes an integer multiple of 2^-149, and the
    // difference is then truncated to 24 significant bits.
    function automatic logic [33:0] ref_lane(input logic [31:0] a, input logic [31:0] b);
        logic [299:0] ma, mb, mag, sg;
        logic         sign, sa, sn;
        int           p, e;
        sa = a[31];
        sn = ~b[31];
        ma = (a[30:23] == 8'd0) ? '0 : ({276'd0, 1'b1, a[22:0]} << (int'(a[30:23]) - 1));
        mb = (b[30:23] == 8'd0) ? '0 : ({276'd0, 1'b1, b[22:0]} << (int'(b[30:23]) - 1));
        if (sa == sn) begin
            mag = ma + mb; sign = sa;
        end else if (ma >= mb) begin
            mag = ma - mb; sign = sa;
        end else begin
            mag = mb - ma; sign = sn;
        end
        if (mag == '0) return 34'd0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e >= 255) return {sign, 31'h7F7FFFFF, 2'b10};
        if (e <= 0) return {32'd0, 2'b01};
        sg = (p >= 23) ? (mag >> (p - 23)) : (mag << (23 - p));
        return {sign, 8'(e), sg[22:0], 2'b00};
    endfunction

    function automatic exp_t model(input logic [0:127] a, input logic [0:127] b, input logic [0:6] addr);
        exp_t        m;
        logic [33:0] t;
        for (int k = 0; k < 4; k++) begin
            t = ref_lane(a[32*k +: 32], b[32*k +: 32]);
            m.res[32*k +: 32] = t[33:2];
            m.ovf[k] = t[1];
            m.unf[k] = t[0];
        end
        m.addr = addr;
        m.edge_out = 0;
        return m;
    endfunction

    function automatic logic [31:0] rnd_word(input int unsigned emin, input int unsigned emax);
        logic [31:0] w;
        w[31]    = 1'($urandom_range(1, 0));
        w[30:23] = 8'($urandom_range(emax, emin));
        w[22:0]  = 23'($urandom);
        return w;
    endfunction

    // Often picks an rb close to ra so that cancellation paths are exercised.
    function automatic logic [31:0] near_word(input logic [31:0] a, input int unsigned emin, input int unsigned emax);
        logic [31:0] w;
        int          e;
        w = rnd_word(emin, emax);
        if ($urandom_range(1, 0) == 1) begin
            e = int'(a[30:23]) + int'($urandom_range(4, 0)) - 2;
            if (e < int'(emin)) e = int'(emin);
            if (e > int'(emax)) e = int'(emax);
            w[30:23] = 8'(e);
            if ($urandom_range(1, 0) == 1) w[22:0] = a[22:0] ^ 23'($urandom_range(15, 0));
        end
        return w;
    endfunction

    task automatic gen(input int unsigned emin, input int unsigned emax,
                       output logic [0:127] a, output logic [0:127] b);
        logic [31:0] wa;
        for (int k = 0; k < 4; k++) begin
            wa = rnd_word(emin, emax);
            a[32*k +: 32] = wa;
            b[32*k +: 32] = near_word(wa, emin, emax);
        end
    endtask

    // Drive one cycle of inputs, then record what that edge must produce.
    task automatic step(input logic v, input logic f, input logic [0:127] a, input logic [0:127] b,
                        input logic [0:6] addr, input bit directed, input logic [0:127] xres,
                        input logic [0:3] xo, input logic [0:3] xu);
        exp_t e;
        in_valid = v; flush = f; ra = a; rb = b; rt_addr = addr;
        @(posedge clk);
        #1;
        if (f) begin
            sbq.delete();
        end else if (v) begin
            if (directed) begin
                e.res = xres; e.addr = addr; e.ovf = xo; e.unf = xu;
            end else begin
                e = model(a, b, addr);
            end
            e.edge_out = cyc + 6;
            sbq.push_back(e);
        end
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, ra, rb, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic issue_rand(input logic v, input logic f, input logic [0:6] addr,
                              input int unsigned emin, input int unsigned emax);
        logic [0:127] a, b;
        gen(emin, emax, a, b);
        step(v, f, a, b, addr, 1'b0, '0, '0, '0);
    endtask

    // Monitor: pops one expectation per out_valid and otherwise checks that outputs hold.
    logic [0:127] last_res = '0;
    logic [0:6]   last_addr = '0;
    logic [0:3]   last_ovf = '0, last_unf = '0;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_res <= '0; last_addr <= '0; last_ovf <= '0; last_unf <= '0;
        end else if (out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got out_valid=1 addr=%0d required no output", rt_wr_addr);
            end else begin
                mon_e = sbq.pop_front();
                chk("latency_edge", 128'(cyc), 128'(mon_e.edge_out));
                chk("result", result, mon_e.res);
                chk("rt_wr_addr", 128'(rt_wr_addr), 128'(mon_e.addr));
                chk("ovf", 128'(ovf), 128'(mon_e.ovf));
                chk("unf", 128'(unf), 128'(mon_e.unf));
                $display("op addr=%0d result=%h ovf=%b unf=%b", rt_wr_addr, result, ovf, unf);
            end
            last_res <= result; last_addr <= rt_wr_addr; last_ovf <= ovf; last_unf <= unf;
        end else begin
            chk("hold_result", result, last_res);
            chk("hold_addr", 128'(rt_wr_addr), 128'(last_addr));
            chk("hold_flags", 128'({ovf, unf}), 128'({last_ovf, last_unf}));
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_result"}, result, 128'(0));
        chk({tag, "_rt_wr_addr"}, 128'(rt_wr_addr), 128'(0));
        chk({tag, "_ovf_unf"}, 128'({ovf, unf}), 128'(0));
    endtask

    initial begin
        logic [0:127] a, b;
        exp_t         e;
        int           waited;

        // Reset with X operands on the inputs.
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic subtract and latency.
        step(1'b1, 1'b0, {4{32'h40400000}}, {4{32'h3F800000}}, 7'd5, 1'b1,
             {4{32'h40000000}}, 4'b0000, 4'b0000);
        idle(8);

        // Sign, truncation and zero-exponent handling.
        step(1'b1, 1'b0, {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h4B800000},
             {32'h40000000, 32'h33000000, 32'h00000001, 32'h3F800000}, 7'd17, 1'b1,
             {32'hBF800000, 32'h3F7FFFFF, 32'h3F800000, 32'h4B7FFFFF}, 4'b0000, 4'b0000);
        // Clamping.
        step(1'b1, 1'b0, {32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00800001, 32'h3F800000},
             {32'hFF7FFFFF, 32'h7F7FFFFF, 32'h00800000, 32'h3F800000}, 7'd99, 1'b1,
             {32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00000000, 32'h00000000}, 4'b1100, 4'b0010);
        idle(8);

        // Back-to-back: ten ops, addresses 0..9, normal operands.
        for (int i = 0; i < 10; i++) issue_rand(1'b1, 1'b0, 7'(i), 1, 254);
        idle(8);

        // Flush arrives together with op 4.
        for (int i = 0; i < 8; i++) issue_rand(1'b1, (i == 4), 7'(40 + i), 1, 254);
        idle(8);

        // Asynchronous reset while three ops are in flight.
        for (int i = 0; i < 3; i++) issue_rand(1'b1, 1'b0, 7'(60 + i), 1, 254);
        #2 rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        gen(1, 254, a, b);
        in_valid = 1'b1; ra = a; rb = b; rt_addr = 7'd77;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        e = model(a, b, 7'd77);
        e.edge_out = cyc + 6;
        sbq.push_back(e);
        in_valid = 1'b0;
        idle(8);

        // Random traffic over the full exponent range, with gaps and rare flushes.
        for (int i = 0; i < 300; i++)
            issue_rand(($urandom_range(3, 0) != 0), ($urandom_range(39, 0) == 0),
                       7'($urandom), 0, 255);

        // Drain the pipe within a bounded number of cycles.
        waited = 0;
        while (sbq.size() != 0 && waited < 20) begin
            idle(1);
            waited++;
        end
        idle(2);
        chk("drain_empty", 128'(sbq.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sp_fs_pipe.md
# sp_fs_pipe

Pipelined 128-bit single-precision floating subtract unit for the SP execution pipe: computes rt = ra − rb independently on four 32-bit word lanes. It is the subtractive companion to the combinational floating-add block and uses the same clamping constants, Smax = 0x7F7FFFFF and Smin = 0x00800000. Unlike the adder, it is fully pipelined and has a fixed six-cycle latency, so issue logic can schedule it like any other SP pipe. It carries the target register address alongside the data and supports a pipeline flush on branch mispredict.

## Interface
- No parameters. Lane count (4), latency (6) and word width (32) are fixed.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation presented this cycle.
- ra  input  [0:127]  minuend. Word k occupies bits 32k..32k+31; bit 0 is the MSB.
- rb  input  [0:127]  subtrahend, same lane layout as ra.
- rt_addr  input  [0:6]  destination register address; carried through the pipe.
- flush  input  1  synchronous kill of all in-flight operations.
- out_valid  output  1  result valid this cycle.
- result  output  [0:127]  ra − rb per lane.
- rt_wr_addr  output  [0:6]  rt_addr of the completing operation.
- ovf  output  [0:3]  per-lane saturation-to-Smax flag.
- unf  output  [0:3]  per-lane flush-to-zero flag.

## Operation
- Operand format:
  - Sign, 8-bit biased exponent, 23-bit fraction with an implicit leading 1.
  - A biased exponent of 0 means the operand is zero, regardless of its fraction bits.
  - Exponent 255 is extended range: the operand is an ordinary number 2^128 × 1.f. There are no Inf/NaN encodings.
- Arithmetic:
  - The result is the exact value ra − rb, truncated toward zero to a 24-bit significand.
  - Alignment keeps guard/sticky information so that truncation of the exact difference is correct, including borrow from shifted-out bits.
- Clamping, evaluated after normalization:
  - If the biased exponent is ≥ 255 and the result is nonzero: output is sign | 0x7F7FFFFF (0x7F7FFFFF or 0xFF7FFFFF), and ovf[k] = 1.
  - If the result is nonzero and its magnitude is below Smin: output is 0x00000000, and unf[k] = 1.
  - If the exact difference is 0: output is 0x00000000 (always +0), and unf[k] = 0.
  - Otherwise: output is the normally packed word, with ovf[k] = unf[k] = 0.
- Lanes are fully independent; there is no cross-lane carry.
- Stage allocation:
  - S1: unpack, invert rb sign, compare magnitudes, swap.
  - S2: align the smaller operand (shift ≥ 26 collapses into sticky).
  - S3: 27-bit significand add/subtract.
  - S4: leading-zero count.
  - S5: normalize shift and exponent adjust.
  - S6: clamp, pack, output register.
- Each stage holds a valid bit and an rt_addr copy.

## Timing
- Latency: an operation accepted on edge N (in_valid = 1, flush = 0) completes with out_valid = 1 after edge N+6.
- Throughput: one operation per cycle. There is no backpressure and no stall input.
- result, rt_wr_addr, ovf and unf are registered. They hold their last values while out_valid = 0.
- flush:
  - At the next edge, all six stage valid bits clear.
  - An operation presented in the same cycle as flush is discarded; flush dominates in_valid.
  - out_valid is 0 in the cycle after flush.
  - Operations issued in the following cycle complete normally six cycles later.
  - Data registers are not cleared by flush.
- Reset (rst_n = 0), including mid-stream:
  - Immediately clears all stage valid bits, out_valid, result, rt_wr_addr, ovf and unf to 0.
  - No pre-reset operation emerges after release.
  - The first operation may be accepted on the first edge with rst_n = 1.
- out_valid is never X after reset, even if ra/rb are X while in_valid = 0.

## Test plan
- **Basic subtract and latency:** every lane ra = 0x40400000, rb = 0x3F800000, in_valid for one cycle at edge 0.
  - out_valid = 1 only after edge 6.
  - result = 0x40000000 in all lanes; rt_wr_addr = the issued rt_addr; ovf = unf = 0.
- **Sign, truncation and zero-exponent handling, one operation across four lanes:**
  - Lane 0: 0x3F800000 − 0x40000000 → 0xBF800000.
  - Lane 1: 0x3F800000 − 0x33000000 → 0x3F7FFFFF (truncated).
  - Lane 2: 0x3F800000 − 0x00000001 → 0x3F800000 (rb treated as zero).
  - Lane 3: 0x4B800000 − 0x3F800000 → 0x4B7FFFFF.
- **Clamping:**
  - Lane 0: 0x7F7FFFFF − 0xFF7FFFFF → 0x7F7FFFFF, ovf[0] = 1.
  - Lane 1: 0xFF7FFFFF − 0x7F7FFFFF → 0xFF7FFFFF, ovf[1] = 1.
  - Lane 2: 0x00800001 − 0x00800000 → 0x00000000, unf[2] = 1.
  - Lane 3: 0x3F800000 − 0x3F800000 → 0x00000000, unf[3] = 0.
- **Back-to-back issue:** 10 consecutive ops, each with a distinct rt_addr 0..9 and random normal operands.
  - out_valid is high for exactly 10 consecutive cycles starting at edge 6.
  - Results and addresses come out in order and match the reference model.
- **Flush:** continuous issue of ops 0..7 with flush asserted in the cycle that presents op 4.
  - Ops 0..3 and op 4 never emerge.
  - Ops 5..7 emerge 6 cycles after issue with correct rt_wr_addr.
- **Asynchronous reset mid-stream:** 3 ops in flight, rst_n dropped mid-cycle.
  - out_valid and all outputs go to 0 without waiting for a clock edge.
  - After release, no stale op appears.
  - An op issued on the first post-reset edge completes 6 cycles later.
